// File: rtl/td4_seq_ctrl.sv
// td4_seq_ctrl: two-phase FETCH/EXEC sequencer for the 4-bit TD4 datapath.
// Ports: clk, reset (async, active-high); instr = ROM byte at PC; alu_co = adder carry;
// im = immediate (ir[3:0]); sel = adder operand source (0=A, 1=B, 2=IN, 3=zero);
// ld_a/ld_b/ld_out = register load enables; pc_en/pc_load = PC increment/load;
// c_flag = carry flag for JNC; phase = 0 FETCH / 1 EXEC.
// Optional SEQ_STEP_EN macro: adds step input and wait_step output, with a HOLD state after EXEC.
module td4_seq_ctrl #(
    parameter int OPW = 4,
    parameter int IMW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPW+IMW-1:0] instr,
    input  logic               alu_co,
    output logic [IMW-1:0]     im,
    output logic [1:0]         sel,
    output logic               ld_a,
    output logic               ld_b,
    output logic               ld_out,
    output logic               pc_en,
    output logic               pc_load,
    output logic               c_flag,
    output logic               phase
`ifdef SEQ_STEP_EN
    ,
    input  logic               step,
    output logic               wait_step
`endif
);
    typedef enum logic [1:0] {FETCH, EXEC, HOLD} state_t;
    state_t state;
    logic [OPW+IMW-1:0] ir;
    logic [OPW-1:0] op;
    logic exec, alu_op, take;
    assign op = ir[OPW+IMW-1:IMW];
    assign exec = state == EXEC;
    // Opcodes 0xxx, 1001 and 1011 go through the adder and update the carry.
    assign alu_op = !op[OPW-1] || (!op[OPW-2] && op[0]);
    // JMP always loads; JNC loads only when the previous instruction left no carry.
    assign take = op == OPW'(4'hF) || (op == OPW'(4'hE) && !c_flag);
    assign im = ir[IMW-1:0];
    assign phase = exec;
    assign sel = exec && alu_op ? op[1:0] : 2'd3;
    assign ld_a = exec && !op[OPW-1] && !op[OPW-2];
    assign ld_b = exec && !op[OPW-1] && op[OPW-2];
    assign ld_out = exec && op[OPW-1] && alu_op;
    assign pc_load = exec && take;
    assign pc_en = exec && !take;
`ifdef SEQ_STEP_EN
    assign wait_step = state == HOLD;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ir <= '0;
            c_flag <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir <= instr;
                    state <= EXEC;
                end
                EXEC: begin
                    c_flag <= alu_op && alu_co;
`ifdef SEQ_STEP_EN
                    state <= HOLD;
`else
                    state <= FETCH;
`endif
                end
`ifdef SEQ_STEP_EN
                HOLD: state <= step ? FETCH : HOLD;
`endif
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_td4_seq_ctrl.sv
// tb_td4_seq_ctrl: drives the controller from a small TD4 datapath (ROM, PC, A, B, OUT, adder).
module tb_td4_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dp_rst = 1'b1;
    logic [7:0] instr;
    logic alu_co;
    logic [3:0] im;
    logic [1:0] sel;
    logic ld_a, ld_b, ld_out, pc_en, pc_load, c_flag, phase;
`ifdef SEQ_STEP_EN
    logic step = 1'b1;
    logic wait_step;
`endif
    logic [7:0] rom [16];
    logic [3:0] pc, a, b, outp, opa;
    logic [4:0] sum5;
    logic [12:0] obs;
    int passed = 0;
    int total = 0;
    typedef struct {
        string tag;
        logic [12:0] v;
    } exp_t;
    exp_t q[$];

    td4_seq_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_co(alu_co), .im(im), .sel(sel),
        .ld_a(ld_a), .ld_b(ld_b), .ld_out(ld_out), .pc_en(pc_en), .pc_load(pc_load),
        .c_flag(c_flag), .phase(phase)
`ifdef SEQ_STEP_EN
        , .step(step), .wait_step(wait_step)
`endif
    );

    always #5 clk = ~clk;

    assign instr = rom[pc];
    assign opa = sel == 2'd0 ? a : sel == 2'd1 ? b : sel == 2'd2 ? 4'h9 : 4'h0;
    assign sum5 = {1'b0, opa} + {1'b0, im};
    assign alu_co = sum5[4];
    assign obs = {phase, sel, im, ld_a, ld_b, ld_out, pc_en, pc_load, c_flag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 4'h0;
        else if (pc_load) pc <= im;
        else if (pc_en) pc <= pc + 4'h1;
    end

    always_ff @(posedge clk) begin
        if (dp_rst) begin
            a <= 4'h0;
            b <= 4'h0;
            outp <= 4'h0;
        end else begin
            if (ld_a) a <= sum5[3:0];
            if (ld_b) b <= sum5[3:0];
            if (ld_out) outp <= sum5[3:0];
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // en = {ld_a, ld_b, ld_out, pc_en, pc_load}; cx = flag during EXEC, ca = flag after EXEC.
    task automatic run(input string tag, input logic [1:0] s, input logic [3:0] i,
                       input logic [4:0] en, input logic cx, input logic ca, input logic [3:0] npc);
        exp_t e;
        q.push_back('{{tag, "_exec"}, {1'b1, s, i, en, cx}});
        q.push_back('{{tag, "_fetch"}, {1'b0, 2'd3, i, 5'b0, ca}});
        repeat (2) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            chk(e.tag, 16'(obs), 16'(e.v));
        end
        chk({tag, "_pc"}, 16'(pc), 16'(npc));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dp_rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        #2;
        chk("reset_outputs", 16'(obs), 16'({1'b0, 2'd3, 4'h0, 5'b0, 1'b0}));
        do_reset();
        run("nop_add0_a", 2'd0, 4'h0, 5'b10010, 1'b0, 1'b0, 4'h1);
        run("nop_add0_b", 2'd0, 4'h0, 5'b10010, 1'b0, 1'b0, 4'h2);
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE7; rom[3] = 8'hE0;
        do_reset();
        run("mov_a_f", 2'd3, 4'hF, 5'b10010, 1'b0, 1'b0, 4'h1);
        chk("a_after_mov", 16'(a), 16'hF);
        run("add_a_1", 2'd0, 4'h1, 5'b10010, 1'b0, 1'b1, 4'h2);
        chk("a_after_add", 16'(a), 16'h0);
        run("jnc_not_taken", 2'd3, 4'h7, 5'b00010, 1'b1, 1'b0, 4'h3);
        run("jnc_taken", 2'd3, 4'h0, 5'b00001, 1'b0, 1'b0, 4'h0);
        rom[0] = 8'hF5; rom[5] = 8'h3F; rom[6] = 8'h01; rom[7] = 8'h80;
        rom[8] = 8'h56; rom[9] = 8'h90; rom[10] = 8'h0A; rom[11] = 8'h30;
        do_reset();
        run("jmp_5", 2'd3, 4'h5, 5'b00001, 1'b0, 1'b0, 4'h5);
        run("mov_a_f2", 2'd3, 4'hF, 5'b10010, 1'b0, 1'b0, 4'h6);
        run("add_a_1b", 2'd0, 4'h1, 5'b10010, 1'b0, 1'b1, 4'h7);
        run("undef_80", 2'd3, 4'h0, 5'b00010, 1'b1, 1'b0, 4'h8);
        run("add_b_6", 2'd1, 4'h6, 5'b01010, 1'b0, 1'b0, 4'h9);
        chk("b_after_add", 16'(b), 16'h6);
        run("out_b", 2'd1, 4'h0, 5'b00110, 1'b0, 1'b0, 4'hA);
        chk("out_after_out_b", 16'(outp), 16'h6);
        run("add_a_a", 2'd0, 4'hA, 5'b10010, 1'b0, 1'b0, 4'hB);
        chk("a_after_add_a", 16'(a), 16'hA);
        @(posedge clk);
        #1;
        chk("exec_30", 16'(obs), 16'({1'b1, 2'd3, 4'h0, 5'b10010, 1'b0}));
        reset = 1'b1;
        #1;
        chk("reset_mid_exec", 16'(obs), 16'({1'b0, 2'd3, 4'h0, 5'b0, 1'b0}));
        @(posedge clk);
        #1;
        chk("a_kept_on_abort", 16'(a), 16'hA);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_fetch_addr0", 16'(obs), 16'({1'b1, 2'd3, 4'h5, 5'b00001, 1'b0}));
        chk("scoreboard_drained", 16'(q.size()), 16'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
